// File: rtl/instr_register_exec.sv
// Instruction register with a 2-stage result pipeline: stores DEPTH entries of
// {opcode, operands, signed result, error} with per-entry valid bits and occupancy.
module instr_register_exec #(
   parameter int OP_W  = 32,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_en,
   input  logic [AW-1:0]        write_pointer,
   input  logic [3:0]           opcode,
   input  logic [OP_W-1:0]      operand_a,
   input  logic [OP_W-1:0]      operand_b,
   input  logic                 clear,
   input  logic                 rd_en,
   input  logic [AW-1:0]        read_pointer,
   output logic                 rd_valid,
   output logic                 rd_entry_valid,
   output logic [3:0]           rd_opcode,
   output logic [OP_W-1:0]      rd_operand_a,
   output logic [OP_W-1:0]      rd_operand_b,
   output logic [2*OP_W-1:0]    rd_result,
   output logic                 rd_err,
   output logic                 wb_busy,
   output logic [AW:0]          count
);

   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   logic                     s1_valid;
   logic [AW-1:0]            s1_ptr;
   logic [3:0]               s1_op;
   logic [OP_W-1:0]          s1_a;
   logic [OP_W-1:0]          s1_b;

   logic                     s2_valid;
   logic [AW-1:0]            s2_ptr;
   logic [3:0]               s2_op;
   logic [OP_W-1:0]          s2_a;
   logic [OP_W-1:0]          s2_b;
   logic [2*OP_W-1:0]        s2_result;
   logic                     s2_err;

   logic [DEPTH-1:0]         entry_valid;
   logic [3:0]               mem_op     [DEPTH];
   logic [OP_W-1:0]          mem_a      [DEPTH];
   logic [OP_W-1:0]          mem_b      [DEPTH];
   logic [2*OP_W-1:0]        mem_result [DEPTH];
   logic                     mem_err    [DEPTH];

   logic signed [2*OP_W-1:0] ext_a;
   logic signed [2*OP_W-1:0] ext_b;
   logic signed [2*OP_W-1:0] calc_result;
   logic                     calc_err;

   logic                     wb_en;
   logic                     wb_hit;
   logic                     nxt_entry_valid;
   logic [3:0]               nxt_op;
   logic [OP_W-1:0]          nxt_a;
   logic [OP_W-1:0]          nxt_b;
   logic [2*OP_W-1:0]        nxt_result;
   logic                     nxt_err;

   // Operands are sign-extended first so MULT is exact and DIV of the most
   // negative value by -1 cannot overflow.
   always_comb begin
      ext_a       = {{OP_W{s1_a[OP_W-1]}}, s1_a};
      ext_b       = {{OP_W{s1_b[OP_W-1]}}, s1_b};
      calc_result = '0;
      calc_err    = 1'b0;
      case (s1_op)
         ZERO:  calc_result = '0;
         PASSA: calc_result = ext_a;
         PASSB: calc_result = ext_b;
         ADD:   calc_result = ext_a + ext_b;
         SUB:   calc_result = ext_a - ext_b;
         MULT:  calc_result = ext_a * ext_b;
         DIV: begin
            if (ext_b == '0) calc_err = 1'b1;
            else             calc_result = ext_a / ext_b;
         end
         MOD: begin
            if (ext_b == '0) calc_err = 1'b1;
            else             calc_result = ext_a % ext_b;
         end
         default: calc_err = 1'b1;
      endcase
   end

   // Clear flushes both stages and overrides a write being accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_ptr    <= '0;
         s1_op     <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         s2_valid  <= 1'b0;
         s2_ptr    <= '0;
         s2_op     <= '0;
         s2_a      <= '0;
         s2_b      <= '0;
         s2_result <= '0;
         s2_err    <= 1'b0;
      end else if (clear) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= load_en;
         if (load_en) begin
            s1_ptr <= write_pointer;
            s1_op  <= opcode;
            s1_a   <= operand_a;
            s1_b   <= operand_b;
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_ptr    <= s1_ptr;
            s2_op     <= s1_op;
            s2_a      <= s1_a;
            s2_b      <= s1_b;
            s2_result <= calc_result;
            s2_err    <= calc_err;
         end
      end
   end

   assign wb_busy = s1_valid | s2_valid;
   assign wb_en   = s2_valid & ~clear;

   // Occupancy only grows when a writeback lands on an entry not yet valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry_valid <= '0;
         count       <= '0;
      end else if (clear) begin
         entry_valid <= '0;
         count       <= '0;
      end else if (s2_valid) begin
         entry_valid[s2_ptr] <= 1'b1;
         if (!entry_valid[s2_ptr]) count <= count + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wb_en) begin
         mem_op[s2_ptr]     <= s2_op;
         mem_a[s2_ptr]      <= s2_a;
         mem_b[s2_ptr]      <= s2_b;
         mem_result[s2_ptr] <= s2_result;
         mem_err[s2_ptr]    <= s2_err;
      end
   end

   // Read sees the writeback landing on the same edge; invalid entries read as zero.
   assign wb_hit = wb_en && (s2_ptr == read_pointer);

   always_comb begin
      nxt_entry_valid = ~clear & (wb_hit | entry_valid[read_pointer]);
      nxt_op          = '0;
      nxt_a           = '0;
      nxt_b           = '0;
      nxt_result      = '0;
      nxt_err         = 1'b0;
      if (wb_hit) begin
         nxt_op     = s2_op;
         nxt_a      = s2_a;
         nxt_b      = s2_b;
         nxt_result = s2_result;
         nxt_err    = s2_err;
      end else if (nxt_entry_valid) begin
         nxt_op     = mem_op[read_pointer];
         nxt_a      = mem_a[read_pointer];
         nxt_b      = mem_b[read_pointer];
         nxt_result = mem_result[read_pointer];
         nxt_err    = mem_err[read_pointer];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid       <= 1'b0;
         rd_entry_valid <= 1'b0;
         rd_opcode      <= '0;
         rd_operand_a   <= '0;
         rd_operand_b   <= '0;
         rd_result      <= '0;
         rd_err         <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_entry_valid <= nxt_entry_valid;
            rd_opcode      <= nxt_op;
            rd_operand_a   <= nxt_a;
            rd_operand_b   <= nxt_b;
            rd_result      <= nxt_result;
            rd_err         <= nxt_err;
         end
      end
   end

endmodule

// File: tb/tb_instr_register_exec.sv
// Self-checking bench for instr_register_exec: directed scenarios plus a randomized
// run compared against a timestamped write-queue model of the register file.
module tb_instr_register_exec;

   localparam int OP_W  = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              load_en;
   logic [AW-1:0]     write_pointer;
   logic [3:0]        opcode;
   logic [OP_W-1:0]   operand_a;
   logic [OP_W-1:0]   operand_b;
   logic              clear;
   logic              rd_en;
   logic [AW-1:0]     read_pointer;
   logic              rd_valid;
   logic              rd_entry_valid;
   logic [3:0]        rd_opcode;
   logic [OP_W-1:0]   rd_operand_a;
   logic [OP_W-1:0]   rd_operand_b;
   logic [2*OP_W-1:0] rd_result;
   logic              rd_err;
   logic              wb_busy;
   logic [AW:0]       count;

   int n_checks = 0;
   int n_fail   = 0;

   instr_register_exec #(.OP_W(OP_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .load_en        (load_en),
      .write_pointer  (write_pointer),
      .opcode         (opcode),
      .operand_a      (operand_a),
      .operand_b      (operand_b),
      .clear          (clear),
      .rd_en          (rd_en),
      .read_pointer   (read_pointer),
      .rd_valid       (rd_valid),
      .rd_entry_valid (rd_entry_valid),
      .rd_opcode      (rd_opcode),
      .rd_operand_a   (rd_operand_a),
      .rd_operand_b   (rd_operand_b),
      .rd_result      (rd_result),
      .rd_err         (rd_err),
      .wb_busy        (wb_busy),
      .count          (count)
   );

   always #5 clk = ~clk;

   // Model: each accepted load becomes visible in the table two edges later.
   typedef struct {
      int          due;
      logic [4:0]  ptr;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } wr_t;

   wr_t         pend[$];
   int          cycle = 0;
   bit          m_valid [DEPTH];
   logic [3:0]  m_op    [DEPTH];
   logic [31:0] m_a     [DEPTH];
   logic [31:0] m_b     [DEPTH];
   logic [63:0] m_res   [DEPTH];
   bit          m_err   [DEPTH];

   logic        exp_rd_valid, exp_ev, exp_err;
   logic [3:0]  exp_op;
   logic [31:0] exp_a, exp_b;
   logic [63:0] exp_res;

   function automatic void ref_compute(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output logic [63:0] r,
                                       output bit e);
      longint la = longint'($signed(a));
      longint lb = longint'($signed(b));
      longint lr = 0;
      e = 0;
      case (op)
         4'd0: lr = 0;
         4'd1: lr = la;
         4'd2: lr = lb;
         4'd3: lr = la + lb;
         4'd4: lr = la - lb;
         4'd5: lr = la * lb;
         4'd6: if (lb == 0) e = 1; else lr = la / lb;
         4'd7: if (lb == 0) e = 1; else lr = la % lb;
         default: e = 1;
      endcase
      r = lr;
   endfunction

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
      return n;
   endfunction

   task automatic model_reset();
      pend.delete();
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
      exp_rd_valid = 0; exp_ev = 0; exp_op = '0; exp_a = '0; exp_b = '0;
      exp_res = '0; exp_err = 0;
   endtask

   task automatic idle();
      load_en = 0; rd_en = 0; clear = 0;
   endtask

   // One clock edge with the currently driven inputs; leaves time at edge + 1.
   task automatic step();
      wr_t w;
      @(posedge clk);
      cycle++;
      if (clear) begin
         pend.delete();
         for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
      end else begin
         while (pend.size() > 0 && pend[0].due == cycle) begin
            w = pend.pop_front();
            m_valid[w.ptr] = 1;
            m_op[w.ptr] = w.op;
            m_a[w.ptr] = w.a;
            m_b[w.ptr] = w.b;
            ref_compute(w.op, w.a, w.b, m_res[w.ptr], m_err[w.ptr]);
         end
         if (load_en) begin
            w.due = cycle + 2; w.ptr = write_pointer; w.op = opcode;
            w.a = operand_a; w.b = operand_b;
            pend.push_back(w);
         end
      end
      exp_rd_valid = rd_en;
      if (rd_en) begin
         exp_ev = m_valid[read_pointer];
         if (exp_ev) begin
            exp_op = m_op[read_pointer]; exp_a = m_a[read_pointer];
            exp_b = m_b[read_pointer]; exp_res = m_res[read_pointer];
            exp_err = m_err[read_pointer];
         end else begin
            exp_op = '0; exp_a = '0; exp_b = '0; exp_res = '0; exp_err = 0;
         end
      end
      #1;
   endtask

   task automatic load(input logic [4:0] p, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
      load_en = 1; write_pointer = p; opcode = op; operand_a = a; operand_b = b;
   endtask

   task automatic test_reset();
      reset = 1; idle(); write_pointer = '0; read_pointer = '0; opcode = '0;
      operand_a = '0; operand_b = '0;
      @(posedge clk); #1;
      n_checks++;
      if ({count, wb_busy, rd_valid, rd_entry_valid, rd_result} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got count=%0d busy=%0b rdv=%0b res=%0h, expected all 0",
                  count, wb_busy, rd_valid, rd_result);
      end
      reset = 0; model_reset();
      rd_en = 1; read_pointer = 5; step(); idle();
      n_checks++;
      if ({rd_valid, rd_entry_valid, rd_result, count} !== {1'b1, 1'b0, 64'd0, 6'd0}) begin
         n_fail++;
         $display("[TB] FAIL reset_read5: got v=%0b ev=%0b res=%0h count=%0d, expected v=1 ev=0 res=0 count=0",
                  rd_valid, rd_entry_valid, rd_result, count);
      end
   endtask

   task automatic test_add_latency();
      logic [2:0] busy_seen;
      load(2, 4'd3, 32'd7, -32'sd3); step(); idle();
      busy_seen[2] = wb_busy; step();
      busy_seen[1] = wb_busy; step();
      busy_seen[0] = wb_busy;
      n_checks++;
      if (busy_seen !== 3'b110) begin
         n_fail++;
         $display("[TB] FAIL add_wb_busy: got %b, expected 110", busy_seen);
      end
      rd_en = 1; read_pointer = 2; step(); idle();
      n_checks++;
      if ({rd_entry_valid, rd_err, rd_result, count} !== {1'b1, 1'b0, 64'd4, 6'd1}) begin
         n_fail++;
         $display("[TB] FAIL add_read: got ev=%0b err=%0b res=%0h count=%0d, expected ev=1 err=0 res=4 count=1",
                  rd_entry_valid, rd_err, rd_result, count);
      end
   endtask

   task automatic test_arith_directed();
      logic [3:0]  t_op  [7];
      logic [31:0] t_a   [7];
      logic [31:0] t_b   [7];
      logic [63:0] t_res [7];
      logic        t_err [7];
      t_op[0] = 4'd5; t_a[0] = 32'h7FFFFFFF; t_b[0] = 32'h7FFFFFFF; t_res[0] = 64'h3FFFFFFF00000001; t_err[0] = 0;
      t_op[1] = 4'd6; t_a[1] = -32'sd7;      t_b[1] = 32'd2;        t_res[1] = -64'sd3;             t_err[1] = 0;
      t_op[2] = 4'd7; t_a[2] = -32'sd7;      t_b[2] = 32'd2;        t_res[2] = -64'sd1;             t_err[2] = 0;
      t_op[3] = 4'd6; t_a[3] = 32'd5;        t_b[3] = 32'd0;        t_res[3] = 64'd0;               t_err[3] = 1;
      t_op[4] = 4'd9; t_a[4] = 32'd3;        t_b[4] = 32'd4;        t_res[4] = 64'd0;               t_err[4] = 1;
      t_op[5] = 4'd6; t_a[5] = 32'h80000000; t_b[5] = 32'hFFFFFFFF; t_res[5] = 64'h0000000080000000; t_err[5] = 0;
      t_op[6] = 4'd4; t_a[6] = 32'd5;        t_b[6] = 32'd9;        t_res[6] = -64'sd4;             t_err[6] = 0;
      for (int i = 0; i < 7; i++) begin
         load(5'(10 + i), t_op[i], t_a[i], t_b[i]); step();
      end
      idle(); step(); step();
      for (int i = 0; i < 7; i++) begin
         rd_en = 1; read_pointer = 5'(10 + i); step(); idle();
         n_checks++;
         if ({rd_err, rd_result} !== {t_err[i], t_res[i]}) begin
            n_fail++;
            $display("[TB] FAIL arith_%0d: got err=%0b res=%0h, expected err=%0b res=%0h",
                     i, rd_err, rd_result, t_err[i], t_res[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear = 1; step(); clear = 0;
      n_checks++;
      if (count !== 6'd0) begin
         n_fail++; $display("[TB] FAIL b2b_clear_count: got %0d, expected 0", count);
      end
      for (int i = 0; i < 32; i++) begin
         load(5'(i), 4'd3, 32'(i), 32'd100); step();
      end
      load(0, 4'd1, 32'hDEADBEEF, 32'd1); step(); idle();
      n_checks++;
      if (count !== 6'd31) begin
         n_fail++; $display("[TB] FAIL b2b_count31: got %0d, expected 31", count);
      end
      step(); step();
      n_checks++;
      if (count !== 6'd32) begin
         n_fail++; $display("[TB] FAIL b2b_count32: got %0d, expected 32", count);
      end
      rd_en = 1; read_pointer = 0; step(); idle();
      n_checks++;
      if ({rd_opcode, rd_result, count} !== {4'd1, 64'hFFFFFFFFDEADBEEF, 6'd32}) begin
         n_fail++;
         $display("[TB] FAIL b2b_rewrite: got op=%0d res=%0h count=%0d, expected op=1 res=ffffffffdeadbeef count=32",
                  rd_opcode, rd_result, count);
      end
   endtask

   task automatic test_same_addr();
      clear = 1; step(); clear = 0;
      load(7, 4'd1, 32'd11, 32'd0); step();
      load(7, 4'd1, 32'd22, 32'd0); step(); idle();
      step();
      rd_en = 1; read_pointer = 7; step(); idle();
      n_checks++;
      if ({rd_entry_valid, rd_operand_a, count} !== {1'b1, 32'd22, 6'd1}) begin
         n_fail++;
         $display("[TB] FAIL same_addr: got ev=%0b a=%0d count=%0d, expected ev=1 a=22 count=1",
                  rd_entry_valid, rd_operand_a, count);
      end
   endtask

   task automatic test_clear();
      load(3, 4'd3, 32'd1, 32'd2); step(); idle();
      clear = 1; rd_en = 1; read_pointer = 7; step(); idle();
      n_checks++;
      if ({rd_valid, rd_entry_valid, count, wb_busy} !== {1'b1, 1'b0, 6'd0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL clear_edge: got v=%0b ev=%0b count=%0d busy=%0b, expected v=1 ev=0 count=0 busy=0",
                  rd_valid, rd_entry_valid, count, wb_busy);
      end
      step(); step();
      rd_en = 1; read_pointer = 3; step(); idle();
      n_checks++;
      if ({rd_entry_valid, count} !== {1'b0, 6'd0}) begin
         n_fail++;
         $display("[TB] FAIL clear_ptr3: got ev=%0b count=%0d, expected ev=0 count=0",
                  rd_entry_valid, count);
      end
   endtask

   task automatic test_reset_midpipe();
      load(6, 4'd2, 32'd0, 32'd55); step(); idle(); step(); step();
      load(4, 4'd1, 32'd1, 32'd1); step();
      load(5, 4'd1, 32'd2, 32'd2); rd_en = 1; read_pointer = 6; step(); idle();
      n_checks++;
      if ({rd_entry_valid, rd_result, count, wb_busy} !== {1'b1, 64'd55, 6'd1, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL midpipe_pre: got ev=%0b res=%0h count=%0d busy=%0b, expected ev=1 res=37 count=1 busy=1",
                  rd_entry_valid, rd_result, count, wb_busy);
      end
      #2 reset = 1;
      #1;
      n_checks++;
      if ({rd_valid, rd_entry_valid, rd_result, count, wb_busy} !== '0) begin
         n_fail++;
         $display("[TB] FAIL midpipe_async: got v=%0b ev=%0b res=%0h count=%0d busy=%0b, expected all 0",
                  rd_valid, rd_entry_valid, rd_result, count, wb_busy);
      end
      model_reset();
      @(posedge clk); #1 reset = 0;
      step(); step();
      for (int p = 4; p <= 5; p++) begin
         rd_en = 1; read_pointer = 5'(p); step(); idle();
         n_checks++;
         if ({rd_entry_valid, count} !== {1'b0, 6'd0}) begin
            n_fail++;
            $display("[TB] FAIL midpipe_ptr%0d: got ev=%0b count=%0d, expected ev=0 count=0",
                     p, rd_entry_valid, count);
         end
      end
   endtask

   task automatic test_random();
      logic [134:0] got, want;
      clear = 1; step(); clear = 0;
      for (int i = 0; i < 400; i++) begin
         load_en = ($urandom_range(0, 3) != 0);
         write_pointer = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         opcode = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         operand_a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
         case ($urandom_range(0, 4))
            0: operand_b = 32'd0;
            1: operand_b = 32'hFFFFFFFF;
            2: operand_b = 32'($urandom_range(1, 20));
            default: operand_b = 32'($urandom);
         endcase
         rd_en = ($urandom_range(0, 1) != 0);
         read_pointer = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         clear = ($urandom_range(0, 39) == 0);
         step();
         n_checks++;
         if (count !== 6'(model_count())) begin
            n_fail++;
            $display("[TB] FAIL rand_count@%0d: got %0d, expected %0d", i, count, model_count());
         end
         n_checks++;
         if (wb_busy !== (pend.size() != 0)) begin
            n_fail++;
            $display("[TB] FAIL rand_busy@%0d: got %0b, expected %0b", i, wb_busy, pend.size() != 0);
         end
         got  = {rd_valid, rd_entry_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err};
         want = {exp_rd_valid, exp_ev, exp_op, exp_a, exp_b, exp_res, exp_err};
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL rand_read@%0d: got %h, expected %h", i, got, want);
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_arith_directed();
      test_back_to_back();
      test_same_addr();
      test_clear();
      test_reset_midpipe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
